// File: rtl/exp_normalize_seq_if.sv
// Handshake bundle for the FP add/sub normalizer. Upstream carries the raw
// adder result, downstream carries the normalized exponent/mantissa pair.
interface exp_normalize_seq_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  // Upstream side
  logic              i_valid;
  logic              o_ready;
  logic              i_sign;
  logic [EXP_W-1:0]  i_exp;
  logic [MANT_W+1:0] i_mant;

  // Downstream side
  logic              o_valid;
  logic              i_ready;
  logic              o_sign;
  logic [EXP_W-1:0]  o_exp;
  logic [MANT_W:0]   o_mant;
  logic              o_zero;
  logic              o_overflow;
  logic              o_underflow;

  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_mant,
           o_zero, o_overflow, o_underflow
  );

  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_mant,
           o_zero, o_overflow, o_underflow
  );
endinterface

// File: rtl/exp_normalize_seq.sv
// Sequential normalizer: recombines the greater exponent with the raw adder
// mantissa, shifting one bit per cycle, truncating (rounding is downstream).
module exp_normalize_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  exp_normalize_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
  localparam logic [EXP_W-1:0]  EXP_ONE  = EXP_W'(1);
  localparam logic [MANT_W+1:0] MANT_NIL = '0;

  state_t             r_state;
  logic               r_ready;
  logic               r_valid;
  logic               r_sign;
  logic [EXP_W-1:0]   r_exp;
  logic [MANT_W+1:0]  r_mant;
  logic               r_zero;
  logic               r_overflow;
  logic               r_underflow;

  logic [EXP_W-1:0]   w_exp_inc;
  logic [EXP_W-1:0]   w_exp_dec;
  logic               w_exp_sat;
  logic               w_exp_low;
  logic               w_mant_zero;
  logic               w_carry;
  logic               w_hidden;
  logic               w_accept;

  assign w_exp_inc   = r_exp + EXP_ONE;
  assign w_exp_dec   = r_exp - EXP_ONE;
  // Saturate when the increment would land on (or wrap past) all-ones.
  assign w_exp_sat   = (r_exp >= (EXP_MAX - EXP_ONE));
  assign w_exp_low   = (r_exp <= EXP_ONE);
  assign w_mant_zero = (r_mant == MANT_NIL);
  assign w_carry     = r_mant[MANT_W+1];
  assign w_hidden    = r_mant[MANT_W];
  assign w_accept    = bus.i_valid && r_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_valid     <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          // r_ready gates acceptance so nothing is taken in the first cycle after reset.
          if (w_accept) begin
            r_ready     <= 1'b0;
            r_sign      <= bus.i_sign;
            r_exp       <= bus.i_exp;
            r_mant      <= bus.i_mant;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_mant_zero) begin
            r_exp   <= '0;
            r_zero  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (w_carry) begin
            if (w_exp_sat) begin
              r_exp      <= EXP_MAX;
              r_mant     <= '0;
              r_overflow <= 1'b1;
            end else begin
              r_exp  <= w_exp_inc;
              r_mant <= r_mant >> 1;
            end
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (w_hidden) begin
            // A normal mantissa can't carry a zero exponent; bump it to the minimum.
            if (r_exp == '0) begin
              r_exp <= EXP_ONE;
            end
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (w_exp_low) begin
            r_exp       <= '0;
            r_underflow <= 1'b1;
            r_valid     <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= w_exp_dec;
          end
        end

        S_DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready     = r_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_sign      = r_sign;
  assign bus.o_exp       = r_exp;
  assign bus.o_mant      = r_mant[MANT_W:0];
  assign bus.o_zero      = r_zero;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;

endmodule

// File: tb/tb_exp_normalize_seq.sv
// Directed bench for exp_normalize_seq: hand-computed vectors, latency,
// backpressure, back-to-back acceptance and mid-operation reset.
module tb_exp_normalize_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0]  last_exp;
  logic [23:0] last_mant;
  logic [2:0]  last_flags;
  logic        last_sign;

  exp_normalize_seq_if #(.EXP_W(8), .MANT_W(23)) bus ();

  exp_normalize_seq #(.EXP_W(8), .MANT_W(23)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] flags();
    return {bus.o_zero, bus.o_overflow, bus.o_underflow};
  endfunction

  // Called at a negedge with the DUT idle and ready (or about to be).
  task automatic do_op(input string name, input logic sign, input logic [7:0] e,
                       input logic [24:0] m, input int want_lat, input logic [7:0] want_exp,
                       input logic [23:0] want_mant, input logic [2:0] want_flags);
    int lat;
    chk({name, ".ready_in"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_sign  = sign;
    bus.i_exp   = e;
    bus.i_mant  = m;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Garbage after acceptance must be ignored.
    bus.i_sign = ~sign;
    bus.i_exp  = ~e;
    bus.i_mant = ~m;
    while (!bus.o_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    chk({name, ".latency"}, 32'(lat), 32'(want_lat));
    chk({name, ".exp"}, 32'(bus.o_exp), 32'(want_exp));
    chk({name, ".mant"}, 32'(bus.o_mant), 32'(want_mant));
    chk({name, ".sign"}, 32'(bus.o_sign), 32'(sign));
    chk({name, ".flags"}, 32'(flags()), 32'(want_flags));
    chk({name, ".ready_busy"}, 32'(bus.o_ready), 32'd0);
    last_exp   = want_exp;
    last_mant  = want_mant;
    last_flags = want_flags;
    last_sign  = sign;
    $display("op %-10s exp=0x%02h mant=0x%07h -> exp=0x%02h mant=0x%06h zou=%03b lat=%0d",
             name, e, m, bus.o_exp, bus.o_mant, flags(), lat);
  endtask

  task automatic handshake(input string name, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, ".hold_valid"}, 32'(bus.o_valid), 32'd1);
      chk({name, ".hold_ready"}, 32'(bus.o_ready), 32'd0);
      chk({name, ".hold_data"}, {bus.o_sign, flags(), bus.o_exp, bus.o_mant},
          {last_sign, last_flags, last_exp, last_mant});
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk({name, ".post_valid"}, 32'(bus.o_valid), 32'd0);
    chk({name, ".post_ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    int seen_valid;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_mant  = '0;

    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bus.o_ready), 32'd0);
    chk("rst.outs", {bus.o_valid, bus.o_sign, flags(), bus.o_exp, bus.o_mant}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    do_op("normal", 1'b0, 8'h7F, 25'h0800000, 2, 8'h7F, 24'h800000, 3'b000);
    handshake("normal", 0);
    do_op("carry", 1'b1, 8'h80, 25'h1800000, 2, 8'h81, 24'hC00000, 3'b000);
    handshake("carry", 0);
    do_op("cancel", 1'b0, 8'h85, 25'h0100000, 5, 8'h82, 24'h800000, 3'b000);
    handshake("cancel", 3);
    // Back-to-back: accepted on the edge right after the handshake.
    do_op("underflow", 1'b0, 8'h02, 25'h0040000, 3, 8'h00, 24'h080000, 3'b001);
    handshake("underflow", 0);
    do_op("overflow", 1'b1, 8'hFE, 25'h1000000, 2, 8'hFF, 24'h000000, 3'b010);
    handshake("overflow", 0);
    do_op("zero", 1'b0, 8'h40, 25'h0000000, 2, 8'h00, 24'h000000, 3'b100);
    handshake("zero", 0);
    do_op("exp0norm", 1'b0, 8'h00, 25'h0800000, 2, 8'h01, 24'h800000, 3'b000);
    handshake("exp0norm", 0);
    do_op("worst", 1'b1, 8'h7F, 25'h0000001, 25, 8'h68, 24'h800000, 3'b000);
    handshake("worst", 0);
    do_op("carryfull", 1'b0, 8'h10, 25'h1FFFFFF, 2, 8'h11, 24'hFFFFFF, 3'b000);
    handshake("carryfull", 1);

    // Reset in the middle of a multi-shift operation.
    bus.i_valid = 1'b1;
    bus.i_exp   = 8'h85;
    bus.i_mant  = 25'h0100000;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.ready", 32'(bus.o_ready), 32'd0);
    chk("midrst.outs", {bus.o_valid, bus.o_sign, flags(), bus.o_exp, bus.o_mant}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.o_valid) seen_valid = 1;
    end
    chk("midrst.no_valid", 32'(seen_valid), 32'd0);
    $display("op midreset aborted, o_ready=%0b", bus.o_ready);

    do_op("afterrst", 1'b1, 8'h7F, 25'h0800000, 2, 8'h7F, 24'h800000, 3'b000);
    handshake("afterrst", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exp_normalize_seq.md
Name: exp_normalize_seq

Overview:
- Multi-cycle normalizer on the far side of the FP add/sub datapath from the exponent compare/swap stage.
- The swap stage splits operands into less/greater exponent. This block takes the greater exponent plus the raw adder mantissa and recombines them into a normalized exponent/mantissa pair.
- Shifts one bit per cycle under an FSM, with valid/ready handshakes on both sides.
- Rounding is done downstream. This block truncates.

Parameters:
- EXP_W, 8, exponent width (biased).
- MANT_W, 23, fraction width. The internal mantissa is MANT_W+2 bits: carry bit, hidden bit, fraction.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream has a result.
- o_ready  out  1  block can accept (high only in IDLE).
- i_sign  in  1  result sign, passed through unchanged.
- i_exp  in  EXP_W  greater exponent from the swap stage.
- i_mant  in  MANT_W+2  raw adder mantissa; [MANT_W+1] = carry, [MANT_W] = hidden.
- o_valid  out  1  result available (high only in DONE).
- i_ready  in  1  downstream accepts.
- o_sign  out  1  registered sign.
- o_exp  out  EXP_W  normalized exponent.
- o_mant  out  MANT_W+1  hidden bit + fraction.
- o_zero  out  1  result is zero.
- o_overflow  out  1  exponent saturated to all-ones.
- o_underflow  out  1  result is denormal.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE.
  - All output registers and flags go to 0; o_valid=0.
  - o_ready=0 while reset is asserted, 1 from the first cycle after release.
  - Reset mid-operation aborts the operation; no partial result is emitted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid=1, latch sign, exp and mant into working registers and clear the flags. Go to SHIFT.
- SHIFT evaluates one rule per cycle on the working registers, in this priority:
  1. mant==0: exp<=0, o_zero=1, go to DONE.
  2. mant[MANT_W+1]=1: mant<=mant>>1 (LSB dropped), exp<=exp+1.
     - If exp+1 equals all-ones: exp<=all-ones, mant<=0, o_overflow=1.
     - Go to DONE.
  3. mant[MANT_W]=1: if exp==0 then exp<=1. Go to DONE.
  4. Otherwise, if exp<=1: exp<=0, o_underflow=1, mant held (denormal), go to DONE.
  5. Otherwise: mant<=mant<<1, exp<=exp-1, stay in SHIFT.
- Only one shift occurs per cycle. exp never wraps: it saturates at the all-ones value and floors at 0 via rules 2 and 4.
- DONE:
  - o_valid=1; o_exp, o_mant (= mant[MANT_W:0]), o_sign and the flags are driven from registers.
  - All outputs stay stable while i_ready=0.
  - On i_ready=1, go to IDLE. o_ready rises the following cycle, so there is no same-cycle pass-through.
- Latency:
  - Acceptance edge to o_valid = 2 cycles, plus 1 cycle per left shift.
  - Worst case is mant with only bit 0 set: 2 + MANT_W = 25 cycles.
- Simultaneous events:
  - i_valid is ignored outside IDLE.
  - i_ready is ignored outside DONE.
  - i_sign/i_exp/i_mant changes after acceptance have no effect.
- At most one flag is set per result.

Test Plan:
- Already normal: i_exp=0x7F, i_mant=0x0800000 -> o_exp=0x7F, o_mant=0x800000, no flags, o_valid 2 cycles after acceptance.
- Carry out: i_exp=0x80, i_mant=0x1800000 -> o_exp=0x81, o_mant=0xC00000, latency 2.
- Cancellation: i_exp=0x85, i_mant=0x0100000 -> 3 left shifts, o_exp=0x82, o_mant=0x800000, o_valid 5 cycles after acceptance.
- Boundaries:
  - i_exp=0x02, i_mant=0x0040000 -> o_exp=0x00, o_mant=0x080000, o_underflow=1.
  - i_exp=0xFE, i_mant=0x1000000 -> o_exp=0xFF, o_mant=0, o_overflow=1.
  - i_mant=0 -> o_zero=1, o_exp=0.
- Backpressure and reset:
  - Hold i_ready=0 for 3 cycles in DONE -> outputs stable, o_ready=0. Release, then a back-to-back second op -> accepted 1 cycle after the handshake.
  - Assert i_rst_n=0 mid-SHIFT -> immediate IDLE, all outputs 0, no o_valid.
